// File: rtl/match_capture_fifo.sv
// Capture FIFO behind the 1110 pattern detector: registers each hit, stores the
// following data word, and tracks matches lost to overflow.
module match_capture_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit_in,
  input  logic [N-1:0]  data_in,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow,
  output logic [CW-1:0] drop_cnt,
  input  logic          clr_ovf
);

  logic [N-1:0]  mem_q [DEPTH];
  logic          hit_q,      hit_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   level_q,    level_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic push, pop, accept, drop;

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign full      = (level_q == (AW+1)'(DEPTH));
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // The detector's word trails its hit pulse by one cycle, so the delayed hit is the push.
  always_comb begin
    push   = hit_q;
    pop    = out_valid & out_ready;
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    hit_d      = hit_in;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

    if (accept && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!accept && pop) level_d = level_q - (AW+1)'(1);

    // A clear wins over a drop in the same cycle; that drop goes uncounted.
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      hit_q      <= hit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_in;
  end

endmodule
